// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB-first, stop bit.
// Each bit lasts N clocks, where N is taken from the shared baud configuration word.
module uart_tx #(
    parameter int UART_DATA_WIDTH   = 8,
    parameter int CONFIG_DATA_WIDTH = 32
) (
    input  logic                         i_Clock,
    input  logic                         i_Rst_n,
    input  logic [CONFIG_DATA_WIDTH-1:0] uart_config_data,
    input  logic                         i_Tx_DV,
    input  logic [UART_DATA_WIDTH-1:0]   i_Tx_Byte,
    output logic                         o_Tx_Active,
    output logic                         o_Tx_Serial,
    output logic                         o_Tx_Done
);

    localparam int BIT_W = $clog2(UART_DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t                         state, state_next;
    logic [CONFIG_DATA_WIDTH-1:0]   clk_count, clk_count_next;
    logic [CONFIG_DATA_WIDTH-1:0]   period, period_next;
    logic [BIT_W-1:0]               bit_index, bit_index_next;
    logic [BIT_W-1:0]               bit_index_inc;
    logic [UART_DATA_WIDTH-1:0]     tx_data, tx_data_next;
    logic                           serial_reg, serial_next;
    logic                           active_reg, active_next;
    logic                           done_reg, done_next;
    logic                           terminal;

    assign o_Tx_Serial = serial_reg;
    assign o_Tx_Active = active_reg;
    assign o_Tx_Done   = done_reg;

    assign terminal      = (clk_count == period);
    assign bit_index_inc = bit_index + BIT_W'(1);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            clk_count  <= '0;
            period     <= '0;
            bit_index  <= '0;
            tx_data    <= '0;
            serial_reg <= 1'b1;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            clk_count  <= clk_count_next;
            period     <= period_next;
            bit_index  <= bit_index_next;
            tx_data    <= tx_data_next;
            serial_reg <= serial_next;
            active_reg <= active_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        clk_count_next = clk_count;
        period_next    = period;
        bit_index_next = bit_index;
        tx_data_next   = tx_data;
        serial_next    = serial_reg;
        active_next    = active_reg;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                serial_next = 1'b1;
                active_next = 1'b0;
                if (i_Tx_DV) begin
                    tx_data_next   = i_Tx_Byte;
                    // Period register holds N-1; configs 0 and 1 are clamped to N=2.
                    period_next    = (uart_config_data < CONFIG_DATA_WIDTH'(2)) ?
                                     CONFIG_DATA_WIDTH'(1) :
                                     uart_config_data - CONFIG_DATA_WIDTH'(1);
                    clk_count_next = '0;
                    serial_next    = 1'b0;
                    active_next    = 1'b1;
                    state_next     = START;
                end
            end

            START: begin
                if (terminal) begin
                    clk_count_next = '0;
                    bit_index_next = '0;
                    serial_next    = tx_data[0];
                    state_next     = DATA;
                end else begin
                    clk_count_next = clk_count + CONFIG_DATA_WIDTH'(1);
                end
            end

            DATA: begin
                if (terminal) begin
                    clk_count_next = '0;
                    if (bit_index != LAST_BIT) begin
                        bit_index_next = bit_index_inc;
                        serial_next    = tx_data[bit_index_inc];
                    end else begin
                        bit_index_next = '0;
                        serial_next    = 1'b1;
                        state_next     = STOP;
                    end
                end else begin
                    clk_count_next = clk_count + CONFIG_DATA_WIDTH'(1);
                end
            end

            STOP: begin
                if (terminal) begin
                    clk_count_next = '0;
                    active_next    = 1'b0;
                    done_next      = 1'b1;
                    state_next     = CLEANUP;
                end else begin
                    clk_count_next = clk_count + CONFIG_DATA_WIDTH'(1);
                end
            end

            CLEANUP: begin
                state_next = IDLE;
            end

            default: begin
                state_next  = IDLE;
                serial_next = 1'b1;
                active_next = 1'b0;
            end
        endcase
    end

endmodule
